// File: rtl/clk_div_mux.sv
// rtl/clk_div_mux.sv - glitch-free selectable-ratio clock divider with clock-enable pulse
//
// Purpose:
//   Divides the system clock by a runtime-selectable ratio. NUM_SRC divisor
//   sources are presented on `div`. `sel` picks one of them and `en` gates
//   the output. Changes to the source and to the gate are applied only at a
//   period boundary (counter wrap). As a result, clk_out never emits a
//   shortened high or low phase.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous assert, active-low reset
//   div         in   packed divisors, source i at [i*CNT_W +: CNT_W]
//   sel         in   requested source; indices >= NUM_SRC select source 0
//   en          in   requested output enable
//   clk_out     out  registered, gated divided clock
//   clk_en      out  one-cycle pulse on the first cycle of each enabled period
//   active_sel  out  source currently in effect
//   busy        out  a sel/en request differs from what is in effect

module clk_div_mux #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*CNT_W-1:0] div,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     en,
    output logic                     clk_out,
    output logic                     clk_en,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic             gate;

    logic [SEL_W-1:0] sel_eff;
    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] div_eff;
    logic             wrap;

    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] act_div_nx;
    logic [SEL_W-1:0] active_sel_nx;
    logic             gate_nx;

    // Source decode. An out-of-range select matches no entry, so it keeps
    // the source-0 defaults.
    always_comb begin
        sel_eff = '0;
        div_sel = div[CNT_W-1:0];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_eff = sel;
                div_sel = div[i*CNT_W +: CNT_W];
            end
        end
    end

    // Ratios below 2 cannot form a high and a low phase, so they are clamped.
    assign div_eff = (div_sel < MIN_DIV) ? MIN_DIV : div_sel;

    // act_div is never below 2, so the subtraction cannot underflow.
    assign wrap = (cnt == (act_div - CNT_W'(1)));

    // Next-state: source, ratio and gate are only sampled at the wrap.
    always_comb begin
        cnt_nx        = cnt + CNT_W'(1);
        act_div_nx    = act_div;
        active_sel_nx = active_sel;
        gate_nx       = gate;
        if (wrap) begin
            cnt_nx        = '0;
            act_div_nx    = div_eff;
            active_sel_nx = sel_eff;
            gate_nx       = en;
        end
    end

    // Outputs are registered from next-state values so that they line up
    // with the counter value that is in the register during the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            act_div    <= MIN_DIV;
            active_sel <= '0;
            gate       <= 1'b0;
            clk_out    <= 1'b0;
            clk_en     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            act_div    <= act_div_nx;
            active_sel <= active_sel_nx;
            gate       <= gate_nx;
            clk_out    <= gate_nx & (cnt_nx < (act_div_nx >> 1));
            clk_en     <= gate_nx & (cnt_nx == '0);
            busy       <= (sel_eff != active_sel_nx) | (en != gate_nx);
        end
    end

endmodule
